// File: rtl/alu_control_seq.sv
// alu_control_seq
//   Registered, handshaked ALU-control decoder between ID and EX. Decodes
//   opcode/funct into an ALU operation code plus an illegal-opcode flag and
//   presents the result one cycle later on a valid/ready output stage.
//   MULT/MULTU/DIV/DIVU take no output slot. Instead they run a down-counter
//   that stalls upstream until the HI/LO result is ready.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   opcode/funct valid
//   in_ready   out  block accepts this cycle (combinational)
//   opcode     in   instruction opcode
//   funct      in   instruction funct
//   out_valid  out  registered decode result valid
//   out_ready  in   EX stage consumes result
//   alu_op     out  registered ALU operation code
//   illegal    out  registered: opcode not in decode table
//   md_start   out  one-cycle pulse in the first MD_RUN cycle
//   md_kind    out  {is_div, is_unsigned}, held from accept until back in IDLE
//   md_done    out  one-cycle pulse, HI/LO result valid
//   busy       out  sequencer not idle
//
// state   | meaning
// --------+------------------------------------------------
// IDLE    | decoding; accepts when the output slot is free
// MD_RUN  | multiply/divide in flight, counter running down
// MD_DONE | HI/LO ready, md_done asserted for this cycle
module alu_control_seq #(
    parameter int NB_FUNCTION = 6,
    parameter int NB_OPCODE   = 6,
    parameter int NB_OP_ALU   = 6,
    parameter int MUL_CYCLES  = 4,
    parameter int DIV_CYCLES  = 32,
    parameter int NB_CNT      = 6
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [NB_OPCODE-1:0]   opcode,
    input  logic [NB_FUNCTION-1:0] funct,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [NB_OP_ALU-1:0]   alu_op,
    output logic                   illegal,
    output logic                   md_start,
    output logic [1:0]             md_kind,
    output logic                   md_done,
    output logic                   busy
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] MD_RUN  = 2'd1;
    localparam logic [1:0] MD_DONE = 2'd2;

    localparam logic [NB_CNT-1:0] MUL_LOAD = NB_CNT'(MUL_CYCLES - 1);
    localparam logic [NB_CNT-1:0] DIV_LOAD = NB_CNT'(DIV_CYCLES - 1);

    logic [1:0]           state;
    logic [NB_CNT-1:0]    cnt;
    logic                 is_rtype;
    logic                 is_md;
    logic                 accept;
    logic [NB_OP_ALU-1:0] dec_op;
    logic                 dec_ill;

    assign is_rtype = (opcode == '0);
    // MULT/MULTU/DIV/DIVU share funct prefix 0110; bit 1 = div, bit 0 = unsigned
    assign is_md    = is_rtype && (funct[5:2] == 4'b0110);
    assign in_ready = (state == IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign busy     = (state != IDLE);
    assign md_done  = (state == MD_DONE);

    always_comb begin
        dec_op  = '0;
        dec_ill = 1'b0;
        if (is_rtype) begin
            case (funct)
                6'b100000, 6'b100001: dec_op = 6'b100000;
                6'b100010, 6'b100011: dec_op = 6'b100010;
                6'b000010, 6'b000110: dec_op = 6'b000010;
                6'b000011, 6'b000111: dec_op = 6'b000011;
                6'b000100:            dec_op = 6'b000000;
                // logic/compare/shift functs already equal their ALU code
                default:              dec_op = NB_OP_ALU'(funct);
            endcase
        end else begin
            case (opcode)
                6'b001000, 6'b001001, 6'b100011, 6'b101011,
                6'b100000, 6'b100001, 6'b100100, 6'b100101,
                6'b101000, 6'b101001, 6'b010011: dec_op = 6'b100000;
                6'b001100:            dec_op = 6'b100100;
                6'b001101:            dec_op = 6'b100101;
                6'b001110:            dec_op = 6'b100110;
                6'b001010:            dec_op = 6'b101010;
                6'b001011:            dec_op = 6'b101011;
                6'b000100, 6'b000101: dec_op = 6'b100010;
                6'b001111:            dec_op = 6'b001111;
                default:              dec_ill = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            md_start <= 1'b0;
            md_kind  <= 2'b00;
        end else begin
            md_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept && is_md) begin
                        state    <= MD_RUN;
                        cnt      <= funct[1] ? DIV_LOAD : MUL_LOAD;
                        md_kind  <= {funct[1], funct[0]};
                        md_start <= 1'b1;
                    end
                end
                MD_RUN: begin
                    if (cnt == '0) begin
                        state <= MD_DONE;
                    end else begin
                        cnt <= cnt - NB_CNT'(1);
                    end
                end
                MD_DONE: begin
                    state   <= IDLE;
                    md_kind <= 2'b00;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Output slot: loaded by a non-MD accept, otherwise drained by out_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            alu_op    <= '0;
            illegal   <= 1'b0;
        end else if (accept && !is_md) begin
            out_valid <= 1'b1;
            alu_op    <= dec_op;
            illegal   <= dec_ill;
        end else if (out_ready) begin
            out_valid <= 1'b0;
            alu_op    <= '0;
            illegal   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_control_seq.sv
module tb_alu_control_seq;

    localparam int MUL_N = 4;
    localparam int DIV_N = 32;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [5:0] opcode = '0;
    logic [5:0] funct = '0;
    logic       in_ready, out_valid, illegal, md_start, md_done, busy;
    logic [5:0] alu_op;
    logic [1:0] md_kind;

    alu_control_seq #(
        .NB_FUNCTION(6), .NB_OPCODE(6), .NB_OP_ALU(6),
        .MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N), .NB_CNT(6)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .funct(funct), .out_valid(out_valid),
        .out_ready(out_ready), .alu_op(alu_op), .illegal(illegal),
        .md_start(md_start), .md_kind(md_kind), .md_done(md_done), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // reference decode tables
    logic [5:0] r_map [64];
    logic [5:0] i_map [64];
    bit         i_legal [64];

    // reference timing model, in absolute cycle numbers
    int         cyc;
    bit         m_ov;
    logic [5:0] m_op;
    bit         m_ill;
    bit         md_act;
    int         md_acc;
    int         md_n;
    logic [1:0] md_k;

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        logic [5:0] exp_op;
        bit         exp_ill;
    } dec_vec_t;

    dec_vec_t vecs [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic init_maps();
        logic [5:0] add_ops [11];
        add_ops = '{6'b001000, 6'b001001, 6'b100011, 6'b101011, 6'b100000, 6'b100001,
                    6'b100100, 6'b100101, 6'b101000, 6'b101001, 6'b010011};
        for (int i = 0; i < 64; i++) begin
            r_map[i]   = 6'(i);
            i_map[i]   = 6'b000000;
            i_legal[i] = 1'b0;
        end
        r_map[6'b100001] = 6'b100000;
        r_map[6'b100011] = 6'b100010;
        r_map[6'b000110] = 6'b000010;
        r_map[6'b000111] = 6'b000011;
        r_map[6'b000100] = 6'b000000;
        foreach (add_ops[k]) begin
            i_map[add_ops[k]] = 6'b100000;
            i_legal[add_ops[k]] = 1'b1;
        end
        i_map[6'b001100] = 6'b100100; i_legal[6'b001100] = 1'b1;
        i_map[6'b001101] = 6'b100101; i_legal[6'b001101] = 1'b1;
        i_map[6'b001110] = 6'b100110; i_legal[6'b001110] = 1'b1;
        i_map[6'b001010] = 6'b101010; i_legal[6'b001010] = 1'b1;
        i_map[6'b001011] = 6'b101011; i_legal[6'b001011] = 1'b1;
        i_map[6'b000100] = 6'b100010; i_legal[6'b000100] = 1'b1;
        i_map[6'b000101] = 6'b100010; i_legal[6'b000101] = 1'b1;
        i_map[6'b001111] = 6'b001111; i_legal[6'b001111] = 1'b1;
    endtask

    task automatic model_reset();
        cyc = 0; m_ov = 0; m_op = '0; m_ill = 0; md_act = 0; md_acc = 0; md_n = 0; md_k = 2'b00;
    endtask

    function automatic bit m_in_ready();
        return !md_act && (!m_ov || out_ready);
    endfunction

    function automatic bit m_is_md(input logic [5:0] op, input logic [5:0] fn);
        return (op == 6'd0) && (fn >= 6'd24) && (fn <= 6'd27);
    endfunction

    task automatic model_edge(input bit acc, input logic [5:0] op, input logic [5:0] fn, input bit ordy);
        if (md_act && (cyc - md_acc) >= md_n + 1) md_act = 0;
        if (acc && !m_is_md(op, fn)) begin
            m_ov  = 1;
            m_op  = (op == 6'd0) ? r_map[fn] : i_map[op];
            m_ill = (op == 6'd0) ? 1'b0 : !i_legal[op];
        end else if (ordy) begin
            m_ov = 0; m_op = '0; m_ill = 0;
        end
        if (acc && m_is_md(op, fn)) begin
            md_act = 1;
            md_acc = cyc;
            md_n   = fn[1] ? DIV_N : MUL_N;
            md_k   = fn[1:0];
        end
        cyc++;
    endtask

    task automatic check_all();
        int d;
        d = cyc - md_acc;
        chk("out_valid", out_valid, m_ov);
        chk("alu_op", alu_op, m_op);
        chk("illegal", illegal, m_ill);
        chk("md_start", md_start, md_act && d == 1);
        chk("md_done", md_done, md_act && d == md_n + 1);
        chk("md_kind", md_kind, md_act ? md_k : 2'b00);
        chk("busy", busy, md_act);
    endtask

    // one clock cycle: drive, check in_ready, clock, check registered outputs
    task automatic cycle(input bit v, input logic [5:0] op, input logic [5:0] fn, input bit ordy);
        bit acc;
        in_valid = v; opcode = op; funct = fn; out_ready = ordy;
        #1;
        chk("in_ready", in_ready, m_in_ready());
        acc = v && m_in_ready();
        @(posedge clk);
        model_edge(acc, op, fn, ordy);
        #1;
        check_all();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_alu_op"}, alu_op, 0);
        chk({tag, "_illegal"}, illegal, 0);
        chk({tag, "_md_start"}, md_start, 0);
        chk({tag, "_md_kind"}, md_kind, 0);
        chk({tag, "_md_done"}, md_done, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        bit         got;
        int         done_at;
        logic [5:0] rop, rfn;

        init_maps();
        model_reset();
        vecs[0]  = '{6'b000000, 6'b000110, 6'b000010, 1'b0};
        vecs[1]  = '{6'b000000, 6'b000100, 6'b000000, 1'b0};
        vecs[2]  = '{6'b001110, 6'b010101, 6'b100110, 1'b0};
        vecs[3]  = '{6'b000101, 6'b000000, 6'b100010, 1'b0};
        vecs[4]  = '{6'b111111, 6'b000000, 6'b000000, 1'b1};
        vecs[5]  = '{6'b000000, 6'b100001, 6'b100000, 1'b0};
        vecs[6]  = '{6'b000000, 6'b101011, 6'b101011, 1'b0};
        vecs[7]  = '{6'b000000, 6'b000111, 6'b000011, 1'b0};
        vecs[8]  = '{6'b000000, 6'b010101, 6'b010101, 1'b0};
        vecs[9]  = '{6'b001111, 6'b000000, 6'b001111, 1'b0};
        vecs[10] = '{6'b100011, 6'b000000, 6'b100000, 1'b0};
        vecs[11] = '{6'b001011, 6'b000000, 6'b101011, 1'b0};
        vecs[12] = '{6'b001101, 6'b111111, 6'b100101, 1'b0};
        vecs[13] = '{6'b010000, 6'b000000, 6'b000000, 1'b1};

        // reset held with traffic present
        in_valid = 1; opcode = 6'b000000; funct = 6'b100000; out_ready = 1;
        @(posedge clk); #1;
        chk_all_zero("rst");
        @(posedge clk); #1;
        chk_all_zero("rst_hold");
        in_valid = 0;
        rst_n = 1;
        model_reset();
        cycle(0, 6'b000000, 6'b000000, 1);
        chk("post_rst_out_valid", out_valid, 0);

        // decode sweep, back-to-back with out_ready high
        foreach (vecs[i]) begin
            cycle(1, vecs[i].op, vecs[i].fn, 1);
            chk("dec_valid", out_valid, 1);
            chk("dec_alu_op", alu_op, vecs[i].exp_op);
            chk("dec_illegal", illegal, vecs[i].exp_ill);
        end
        cycle(0, 6'b000000, 6'b000000, 1);

        // backpressure
        cycle(1, 6'b000000, 6'b100000, 1);
        for (int i = 0; i < 3; i++) begin
            cycle(1, 6'b000000, 6'b100010, 0);
            chk("bp_alu_op", alu_op, 6'b100000);
            chk("bp_in_ready", in_ready, 0);
        end
        cycle(1, 6'b000000, 6'b100010, 1);
        chk("bp_release_op", alu_op, 6'b100010);
        cycle(0, 6'b000000, 6'b000000, 1);

        // MULTU: offsets counted from the accept edge
        cycle(1, 6'b000000, 6'b011001, 1);
        chk("mul_start", md_start, 1);
        chk("mul_kind", md_kind, 2'b01);
        for (int d = 2; d <= 6; d++) begin
            cycle(0, 6'b000000, 6'b000000, 1);
            chk("mul_done", md_done, d == 5);
            chk("mul_busy", busy, d <= 5);
            chk("mul_start_low", md_start, 0);
            chk("mul_no_valid", out_valid, 0);
            chk("mul_in_ready", in_ready, d == 6);
        end

        // DIV full latency
        cycle(1, 6'b000000, 6'b011010, 1);
        chk("div_kind", md_kind, 2'b10);
        got = 0; done_at = 0;
        for (int k = 1; k <= 40 && !got; k++) begin
            if (md_done) begin got = 1; done_at = k; end
            else cycle(0, 6'b000000, 6'b000000, 1);
        end
        chk("div_done_latency", done_at, DIV_N + 1);
        cycle(0, 6'b000000, 6'b000000, 1);

        // DIV aborted by reset at cycle 10
        cycle(1, 6'b000000, 6'b011010, 1);
        for (int k = 2; k <= 10; k++) cycle(0, 6'b000000, 6'b000000, 1);
        chk("div_busy_before_rst", busy, 1);
        rst_n = 0;
        #1;
        chk_all_zero("mid_rst");
        model_reset();
        @(posedge clk); #1;
        rst_n = 1;
        for (int k = 0; k < 30; k++) begin
            cycle(0, 6'b000000, 6'b000000, 1);
            chk("no_done_after_rst", md_done, 0);
        end

        // pending output blocks MD accept
        cycle(1, 6'b000000, 6'b100000, 0);
        cycle(1, 6'b000000, 6'b011000, 0);
        chk("pend_busy", busy, 0);
        chk("pend_alu_op", alu_op, 6'b100000);
        cycle(1, 6'b000000, 6'b011000, 1);
        chk("pend_md_start", md_start, 1);
        chk("pend_drained", out_valid, 0);
        for (int k = 0; k < 10 && md_act; k++) cycle(0, 6'b000000, 6'b000000, 1);

        // randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            rop = ($urandom_range(0, 9) < 5) ? 6'd0 : 6'($urandom_range(0, 63));
            if (rop == 6'd0 && $urandom_range(0, 7) == 0)
                rfn = {4'b0110, 2'($urandom_range(0, 3))};
            else
                rfn = 6'($urandom_range(0, 63));
            cycle(1'($urandom_range(0, 1)), rop, rfn, $urandom_range(0, 3) != 0);
        end
        got = 0;
        for (int k = 0; k < 60 && !got; k++) begin
            cycle(0, 6'b000000, 6'b000000, 1);
            got = !md_act && !m_ov;
        end
        chk("drain_timeout", got, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_control_seq.md
# alu_control_seq

Registered, handshaked successor to the combinational ALU-control decoder. Sits between the ID and EX stages: it accepts an opcode/funct pair, decodes it into the ALU operation code and an illegal-instruction flag, and presents the result one cycle later through a valid/ready output stage. It also sequences the multi-cycle MULT/MULTU/DIV/DIVU operations with a cycle counter, stalling upstream until the HI/LO result is ready.

## Interface
- NB_FUNCTION, 6, funct field width
- NB_OPCODE, 6, opcode field width
- NB_OP_ALU, 6, ALU operation code width
- MUL_CYCLES, 4, MD_RUN cycles for MULT/MULTU (≥1)
- DIV_CYCLES, 32, MD_RUN cycles for DIV/DIVU (≥1)
- NB_CNT, 6, counter width (must hold max(MUL_CYCLES, DIV_CYCLES)-1)

- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low
- in_valid  in  1  opcode/funct valid
- in_ready  out  1  block accepts this cycle (combinational)
- opcode  in  NB_OPCODE  instruction opcode
- funct  in  NB_FUNCTION  instruction funct
- out_valid  out  1  registered decode result valid
- out_ready  in  1  EX stage consumes result
- alu_op  out  NB_OP_ALU  registered ALU operation code
- illegal  out  1  registered: opcode not in decode table
- md_start  out  1  one-cycle pulse, first MD_RUN cycle
- md_kind  out  2  {is_div, is_unsigned}, held from accept until return to IDLE
- md_done  out  1  one-cycle pulse, HI/LO result valid
- busy  out  1  state != IDLE

## Operation
- Accept = in_valid && in_ready. in_ready = (state==IDLE) && (!out_valid || out_ready).
- R-type (opcode 000000) map, funct->alu_op: 100000/100001->100000 (ADD); 100010/100011->100010 (SUB); 100100->100100; 100101->100101; 100110->100110; 100111->100111; 101010->101010; 101011->101011 (SLTU); 000000->000000 (SLL); 000010/000110->000010 (SRL); 000011/000111->000011 (SRA); 000100->000000 (SLLV->SLL); any other funct passes through unchanged, illegal=0.
- I-type map: 001000/001001/100011/101011/100000/100001/100100/100101/101000/101001/010011->100000 (ADD); 001100->100100; 001101->100101; 001110->100110; 001010->101010; 001011->101011; 000100/000101->100010 (SUB); 001111->001111 (LUI). Any other opcode->000000 with illegal=1.
- Non-MD accept: alu_op, illegal loaded; out_valid set. Output register held while out_valid && !out_ready; cleared on out_ready with no new accept.
- MD funct (R-type 011000 MULT, 011001 MULTU, 011010 DIV, 011011 DIVU): no out_valid produced. On accept: state->MD_RUN, counter<=N-1 (N=MUL_CYCLES or DIV_CYCLES), md_kind latched.
- FSM: IDLE -> MD_RUN on MD accept. MD_RUN: counter decrements each cycle; when counter==0 -> MD_DONE. MD_DONE: md_done=1 one cycle -> IDLE.
- md_start registered: high exactly in the first MD_RUN cycle.
- Reset asserted at any point (including mid-MD_RUN): state IDLE, counter 0, all outputs 0, the in-flight op is discarded with no md_done.

## Timing
- Reset values: out_valid 0, alu_op 0, illegal 0, md_start 0, md_kind 0, md_done 0, busy 0; in_ready 1 after reset release.
- Decode latency: accept at edge k -> out_valid/alu_op valid after edge k (1 cycle).
- Full throughput: back-to-back accepts every cycle while out_ready=1.
- MD op accepted at edge k: MD_RUN for cycles k+1..k+N, md_start in cycle k+1, md_done in cycle k+N+1, in_ready returns in cycle k+N+2 (given output empty or out_ready).
- MD accept requires the output slot empty or draining (in_ready rule); pending out_valid from a prior op drains normally during MD_RUN.
- Counter never wraps: decrement only when nonzero in MD_RUN.

## Test plan
- Reset mid-stream: hold reset low with in_valid=1 -> all outputs 0; release -> in_ready=1 next cycle, out_valid stays 0 until an accept.
- Decode sweep, out_ready=1: funct 000110 -> alu_op 000010; funct 000100 -> 000000; opcode 001110 -> 100110; opcode 000101 -> 100010; opcode 111111 -> alu_op 000000, illegal=1; all 1-cycle latency, back-to-back.
- Backpressure: accept ADD, hold out_ready=0 for 3 cycles -> alu_op 100000 held, in_ready=0; release -> next op accepted the same cycle.
- MULTU with MUL_CYCLES=4 accepted at edge 0 -> md_kind 01, md_start cycle 1, busy cycles 1-5, md_done cycle 5, in_ready 0 cycles 1-5, no out_valid.
- DIV with DIV_CYCLES=32 -> md_kind 10, md_done exactly 33 cycles after accept; assert reset at cycle 10 -> no md_done, state IDLE.
- Pending ADD with out_ready=0 when MD op presented -> MD not accepted until ADD consumed.
